// File: rtl/sysmanage_executor_if.sv
// System-manage command channel plus per-target flush req/ack handshakes and status.
// The slave modport is the executor; the master modport is the core/cache side.
interface sysmanage_executor_if;
  logic       sm_valid_i;
  logic       sm_ready_o;
  logic [7:0] sm_command_i;
  logic       dflush_req_o;
  logic       dflush_ack_i;
  logic       iflush_req_o;
  logic       iflush_ack_i;
  logic       tlbflush_req_o;
  logic       tlbflush_ack_i;
  logic       busy_o;
  logic       done_o;
  logic       err_o;
  logic [1:0] err_code_o;

  modport slave (
    input  sm_valid_i, sm_command_i, dflush_ack_i, iflush_ack_i, tlbflush_ack_i,
    output sm_ready_o, dflush_req_o, iflush_req_o, tlbflush_req_o,
    output busy_o, done_o, err_o, err_code_o
  );

  modport master (
    output sm_valid_i, sm_command_i, dflush_ack_i, iflush_ack_i, tlbflush_ack_i,
    input  sm_ready_o, dflush_req_o, iflush_req_o, tlbflush_req_o,
    input  busy_o, done_o, err_o, err_code_o
  );
endinterface

// File: rtl/sysmanage_executor.sv
// Queues system-manage commands and sequences D/I/TLB flush handshakes, reporting done/err.
// Optional per-handshake watchdog enabled by defining SYSMANAGE_TIMEOUT_EN.
module sysmanage_executor #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk_i,
  input  logic                 arstn_i,
  sysmanage_executor_if.slave  sm
);
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, REQ_D, REQ_I, REQ_T, DONE, ERR} state_e;

  state_e        state_q, state_d;
  logic [3:0]    fifo_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   cnt_q;
  logic          all_q;
  logic [1:0]    code_q, code_d;
  logic          done_q, done_d, err_q, err_d;
  logic [1:0]    err_code_q, err_code_d;
  logic          dreq_d, ireq_d, treq_d;
  logic          fifo_empty, fifo_full, push, pop, timeout;
  logic [3:0]    head_op;
  logic          unused_arg;

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == (PW+1)'(FIFO_DEPTH));
  assign push       = sm.sm_valid_i && !fifo_full;
  assign head_op    = fifo_q[rd_ptr_q];
  assign unused_arg = ^sm.sm_command_i[3:0];

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  // Only the opcode is stored; the arg nibble is reserved.
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= sm.sm_command_i[7:4];
  end

`ifdef SYSMANAGE_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wd_q;
  logic          in_req;
  assign in_req = (state_q == REQ_D) || (state_q == REQ_I) || (state_q == REQ_T);

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i)                         wd_q <= '0;
    else if (!in_req || state_d != state_q) wd_q <= '0;
    else                                  wd_q <= wd_q + 1'b1;
  end

  assign timeout = in_req && (wd_q == WW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q    <= IDLE;
      all_q      <= 1'b0;
      code_q     <= 2'b00;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      if (pop) all_q <= (head_op == 4'd4);
    end
  end

  // An ack in the same cycle as the watchdog expiry wins.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    unique case (state_q)
      IDLE: if (!fifo_empty) begin
        unique case (head_op)
          4'd0:       state_d = DONE;
          4'd1:       state_d = REQ_I;
          4'd2, 4'd4: state_d = REQ_D;
          4'd3:       state_d = REQ_T;
          default: begin
            state_d = ERR;
            code_d  = 2'b01;
          end
        endcase
      end
      REQ_D: if (sm.dflush_ack_i) state_d = all_q ? REQ_I : DONE;
             else if (timeout) begin state_d = ERR; code_d = 2'b10; end
      REQ_I: if (sm.iflush_ack_i) state_d = all_q ? REQ_T : DONE;
             else if (timeout) begin state_d = ERR; code_d = 2'b10; end
      REQ_T: if (sm.tlbflush_ack_i) state_d = DONE;
             else if (timeout) begin state_d = ERR; code_d = 2'b10; end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Completion strobes are registered, so they appear the cycle after DONE/ERR.
  always_comb begin
    dreq_d     = (state_q == REQ_D);
    ireq_d     = (state_q == REQ_I);
    treq_d     = (state_q == REQ_T);
    pop        = (state_q == IDLE) && !fifo_empty;
    done_d     = (state_q == DONE);
    err_d      = (state_q == ERR);
    err_code_d = (state_q == ERR) ? code_q : 2'b00;
  end

  assign sm.sm_ready_o     = !fifo_full;
  assign sm.dflush_req_o   = dreq_d;
  assign sm.iflush_req_o   = ireq_d;
  assign sm.tlbflush_req_o = treq_d;
  assign sm.busy_o         = !fifo_empty || (state_q != IDLE);
  assign sm.done_o         = done_q;
  assign sm.err_o          = err_q;
  assign sm.err_code_o     = err_code_q;
endmodule
